// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles the ID/EX inputs and EX/MEM outputs of the execute stage.
//   master : upstream side (drives the ID/EX fields, observes stall and EX/MEM)
//   slave  : ex_stage itself
// Signals
//   valid_ex, flush_ex, alu_op[4:0], alu_src, ctrl_ex[4:0], rd_ex[4:0],
//   pc4_ex, rs1_data, rs2_data, imm                     : ID/EX -> EX
//   stall_ex, valid_mem, ctrl_mem[4:0], rd_mem[4:0],
//   pc4_mem, alu_result, write_data                     : EX -> upstream / MEM
interface ex_stage_if;
    logic        valid_ex;
    logic        flush_ex;
    logic [4:0]  alu_op;
    logic        alu_src;
    logic [4:0]  ctrl_ex;
    logic [4:0]  rd_ex;
    logic [31:0] pc4_ex;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;

    logic        stall_ex;
    logic        valid_mem;
    logic [4:0]  ctrl_mem;
    logic [4:0]  rd_mem;
    logic [31:0] pc4_mem;
    logic [31:0] alu_result;
    logic [31:0] write_data;

    modport master (
        output valid_ex, flush_ex, alu_op, alu_src, ctrl_ex, rd_ex, pc4_ex,
               rs1_data, rs2_data, imm,
        input  stall_ex, valid_mem, ctrl_mem, rd_mem, pc4_mem, alu_result, write_data
    );

    modport slave (
        input  valid_ex, flush_ex, alu_op, alu_src, ctrl_ex, rd_ex, pc4_ex,
               rs1_data, rs2_data, imm,
        output stall_ex, valid_mem, ctrl_mem, rd_mem, pc4_mem, alu_result, write_data
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RV32 pipeline.
// Computes single-cycle ALU results and registers them into the EX/MEM register.
// With the macro RV32M_MD_EN defined, an iterative RV32M multiply/divide unit is built
// (MD_BITS_PER_CYCLE bits per cycle, legal 1/2/4); it stalls upstream while an M-op runs.
// Without RV32M_MD_EN, M-ops are single-cycle with result 0 and stall_ex is tied low.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : ex_stage_if.slave (ID/EX fields in, stall and EX/MEM register out)
module ex_stage #(
    parameter int unsigned MD_BITS_PER_CYCLE = 1
) (
    input  logic      clk,
    input  logic      reset,
    ex_stage_if.slave bus
);
    localparam logic [4:0] OpAdd   = 5'd0;
    localparam logic [4:0] OpSub   = 5'd1;
    localparam logic [4:0] OpSll   = 5'd2;
    localparam logic [4:0] OpSlt   = 5'd3;
    localparam logic [4:0] OpSltu  = 5'd4;
    localparam logic [4:0] OpXor   = 5'd5;
    localparam logic [4:0] OpSrl   = 5'd6;
    localparam logic [4:0] OpSra   = 5'd7;
    localparam logic [4:0] OpOr    = 5'd8;
    localparam logic [4:0] OpAnd   = 5'd9;
    localparam logic [4:0] OpPassB = 5'd10;

    if (!(MD_BITS_PER_CYCLE == 1 || MD_BITS_PER_CYCLE == 2 || MD_BITS_PER_CYCLE == 4))
    begin : g_bad_md_bits
        $error("MD_BITS_PER_CYCLE must be 1, 2 or 4");
    end

    logic [31:0] op_a, op_b, alu_out, result;
    logic        issue, capture, stall, md_done;
    logic [31:0] md_result;

    assign op_a  = bus.rs1_data;
    assign op_b  = bus.alu_src ? bus.imm : bus.rs2_data;
    assign issue = bus.valid_ex & ~bus.flush_ex;

    always_comb begin
        alu_out = '0;
        case (bus.alu_op)
            OpAdd:   alu_out = op_a + op_b;
            OpSub:   alu_out = op_a - op_b;
            OpSll:   alu_out = op_a << op_b[4:0];
            OpSlt:   alu_out = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
            OpSltu:  alu_out = (op_a < op_b) ? 32'd1 : 32'd0;
            OpXor:   alu_out = op_a ^ op_b;
            OpSrl:   alu_out = op_a >> op_b[4:0];
            OpSra:   alu_out = $signed(op_a) >>> op_b[4:0];
            OpOr:    alu_out = op_a | op_b;
            OpAnd:   alu_out = op_a & op_b;
            OpPassB: alu_out = op_b;
            default: alu_out = '0;
        endcase
    end

`ifdef RV32M_MD_EN
    localparam int unsigned MdSteps = 32 / MD_BITS_PER_CYCLE;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // Mul: {hi, lo} product/multiplier register. Div: {remainder, quotient/dividend}.
    logic [63:0] work_q, work_d;
    logic [31:0] mag_q, mag_d;     // multiplicand or divisor magnitude
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;     // negate the selected half at the end
    logic [1:0]  sel_q, sel_d;     // alu_op[1:0] of the running M-op

    logic        is_mop;
    logic [2:0]  mop;
    logic        a_signed, b_signed, a_neg, b_neg, special;
    logic [31:0] a_mag, b_mag;
    logic [63:0] step, prod;
    logic [32:0] tmp, sum;
    logic [31:0] lo, hi;

    assign is_mop = (bus.alu_op[4:3] == 2'b10);
    assign mop    = bus.alu_op[2:0];

    always_comb begin
        a_signed = (mop == 3'd1) | (mop == 3'd2) | (mop == 3'd4) | (mop == 3'd6);
        b_signed = (mop == 3'd1) | (mop == 3'd4) | (mop == 3'd6);
        a_neg    = a_signed & op_a[31];
        b_neg    = b_signed & op_b[31];
        a_mag    = a_neg ? (32'd0 - op_a) : op_a;
        b_mag    = b_neg ? (32'd0 - op_b) : op_b;
        // Divide by zero or signed overflow: result is known up front, skip BUSY.
        special  = mop[2] & ((op_b == 32'd0) |
                   (~mop[0] & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF)));
    end

    // MD_BITS_PER_CYCLE radix-2 steps per cycle.
    always_comb begin
        step = work_q;
        tmp  = '0;
        sum  = '0;
        for (int unsigned k = 0; k < MD_BITS_PER_CYCLE; k++) begin
            if (is_div_q) begin
                tmp = {step[63:32], step[31]};
                if (tmp >= {1'b0, mag_q}) begin
                    tmp  = tmp - {1'b0, mag_q};
                    step = {tmp[31:0], step[30:0], 1'b1};
                end else begin
                    step = {tmp[31:0], step[30:0], 1'b0};
                end
            end else begin
                sum  = {1'b0, step[63:32]} + (step[0] ? {1'b0, mag_q} : 33'd0);
                step = {sum, step[31:1]};
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        mag_d    = mag_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        sel_d    = sel_q;
        stall    = 1'b0;
        md_done  = 1'b0;
        case (state_q)
            StIdle: begin
                if (issue && is_mop) begin
                    stall    = 1'b1;
                    is_div_d = mop[2];
                    sel_d    = mop[1:0];
                    cnt_d    = 6'(MdSteps - 1);
                    // REM takes the dividend's sign; everything else the xor of signs.
                    neg_d    = (mop[2] & mop[1]) ? a_neg : (a_neg ^ b_neg);
                    if (special) begin
                        neg_d   = 1'b0;
                        work_d  = (op_b == 32'd0) ? {op_a, 32'hFFFF_FFFF}
                                                  : {32'd0, 32'h8000_0000};
                        state_d = StDone;
                    end else begin
                        work_d  = mop[2] ? {32'd0, a_mag} : {32'd0, b_mag};
                        mag_d   = mop[2] ? b_mag : a_mag;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (bus.flush_ex) begin
                    state_d = StIdle;
                end else begin
                    stall  = 1'b1;
                    work_d = step;
                    if (cnt_q == 6'd0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            StDone: begin
                md_done = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        prod = neg_q ? (64'd0 - work_q) : work_q;
        lo   = neg_q ? (32'd0 - work_q[31:0]) : work_q[31:0];
        hi   = neg_q ? (32'd0 - work_q[63:32]) : work_q[63:32];
        if (is_div_q) begin
            md_result = sel_q[1] ? hi : lo;
        end else begin
            md_result = (sel_q == 2'd0) ? prod[31:0] : prod[63:32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            work_q   <= '0;
            mag_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            mag_q    <= mag_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            sel_q    <= sel_d;
        end
    end
`else
    assign stall     = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
`endif

    assign capture = issue & ~stall;
    assign result  = md_done ? md_result : alu_out;

    logic        valid_q;
    logic [4:0]  ctrl_q, rd_q;
    logic [31:0] pc4_q, res_q, wd_q;

    // Anything not captured (bubble, flush, stall) loads all-zero fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd_q    <= '0;
            pc4_q   <= '0;
            res_q   <= '0;
            wd_q    <= '0;
        end else if (capture) begin
            valid_q <= 1'b1;
            ctrl_q  <= bus.ctrl_ex;
            rd_q    <= bus.rd_ex;
            pc4_q   <= bus.pc4_ex;
            res_q   <= result;
            wd_q    <= bus.rs2_data;
        end else begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd_q    <= '0;
            pc4_q   <= '0;
            res_q   <= '0;
            wd_q    <= '0;
        end
    end

    assign bus.stall_ex   = stall;
    assign bus.valid_mem  = valid_q;
    assign bus.ctrl_mem   = ctrl_q;
    assign bus.rd_mem     = rd_q;
    assign bus.pc4_mem    = pc4_q;
    assign bus.alu_result = res_q;
    assign bus.write_data = wd_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage. An arithmetic reference model gives the result
// and latency of every instruction; one negedge process compares all outputs each cycle,
// and selected instructions also check alu_result against hand-computed literals.
module tb_ex_stage;
`ifdef RV32M_MD_EN
    localparam bit MdEn = 1'b1;
`else
    localparam bit MdEn = 1'b0;
`endif
    localparam int MdN = 32;

    localparam int AbortNone  = 0;
    localparam int AbortFlush = 1;
    localparam int AbortReset = 2;

    logic clk, reset;
    ex_stage_if bus ();

    ex_stage #(.MD_BITS_PER_CYCLE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        chk_en;
    logic        exp_stall, exp_valid;
    logic [4:0]  exp_ctrl, exp_rd;
    logic [31:0] exp_pc4, exp_res, exp_wd;
    logic [31:0] pc_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_ex", {31'd0, bus.stall_ex}, {31'd0, exp_stall});
            chk("valid_mem", {31'd0, bus.valid_mem}, {31'd0, exp_valid});
            chk("ctrl_mem", {27'd0, bus.ctrl_mem}, {27'd0, exp_ctrl});
            chk("rd_mem", {27'd0, bus.rd_mem}, {27'd0, exp_rd});
            chk("pc4_mem", bus.pc4_mem, exp_pc4);
            chk("alu_result", bus.alu_result, exp_res);
            chk("write_data", bus.write_data, exp_wd);
        end
    end

    function automatic logic [31:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (op >= 5'd16 && op <= 5'd23 && !MdEn) return 32'd0;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return $signed(a) >>> b[4:0];
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            5'd16: return a * b;
            5'd17: begin p = sa * sb; return p[63:32]; end
            5'd18: begin p = sa * $signed({32'd0, b}); return p[63:32]; end
            5'd19: begin p = $signed({32'd0, a}) * $signed({32'd0, b}); return p[63:32]; end
            5'd20: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            5'd21: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            5'd23: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (!MdEn || op < 5'd16 || op > 5'd23) return 1;
        if (op >= 5'd20 && (b == 32'd0 ||
            (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
        return MdN + 2;
    endfunction

    task automatic set_bubble();
        exp_valid = 1'b0;
        exp_ctrl  = '0;
        exp_rd    = '0;
        exp_pc4   = '0;
        exp_res   = '0;
        exp_wd    = '0;
    endtask

    task automatic idle(input int n);
        bus.valid_ex = 1'b0;
        bus.flush_ex = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_stall = 1'b0;
            @(posedge clk); #1;
            set_bubble();
        end
    endtask

    // Presents one instruction at post-edge time and walks it to completion (or abort).
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b_reg,
                          input logic [31:0] im, input logic src, input logic [4:0] ctrl,
                          input logic [4:0] rd, input int abort_kind, input int abort_at,
                          input bit use_lit, input logic [31:0] lit);
        logic [31:0] opb, res, pc4;
        int lat;
        opb = src ? im : b_reg;
        res = model_alu(op, a, opb);
        lat = model_lat(op, a, opb);
        pc4 = pc_next;
        pc_next = pc_next + 32'd4;
        bus.valid_ex = 1'b1;
        bus.flush_ex = 1'b0;
        bus.alu_op   = op;
        bus.alu_src  = src;
        bus.ctrl_ex  = ctrl;
        bus.rd_ex    = rd;
        bus.pc4_ex   = pc4;
        bus.rs1_data = a;
        bus.rs2_data = b_reg;
        bus.imm      = im;
        for (int c = 0; c < lat; c++) begin
            if (c == abort_at && abort_kind == AbortReset) begin
                #1;
                bus.valid_ex = 1'b0;
                reset = 1'b1;
                set_bubble();
                exp_stall = 1'b0;
                #1;
                chk("reset_stall", {31'd0, bus.stall_ex}, 32'd0);
                chk("reset_valid", {31'd0, bus.valid_mem}, 32'd0);
                chk("reset_result", bus.alu_result, 32'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            if (c == abort_at && abort_kind == AbortFlush) begin
                bus.flush_ex = 1'b1;
                exp_stall = 1'b0;
                @(posedge clk); #1;
                set_bubble();
                bus.flush_ex = 1'b0;
                bus.valid_ex = 1'b0;
                return;
            end
            exp_stall = (c < lat - 1);
            @(posedge clk); #1;
            if (c == lat - 1) begin
                exp_valid = 1'b1;
                exp_ctrl  = ctrl;
                exp_rd    = rd;
                exp_pc4   = pc4;
                exp_res   = res;
                exp_wd    = b_reg;
            end else begin
                set_bubble();
            end
        end
        if (use_lit) chk("literal_result", bus.alu_result, lit);
    endtask

    initial begin
        reset        = 1'b1;
        bus.valid_ex = 1'b0;
        bus.flush_ex = 1'b0;
        bus.alu_op   = '0;
        bus.alu_src  = 1'b0;
        bus.ctrl_ex  = '0;
        bus.rd_ex    = '0;
        bus.pc4_ex   = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.imm      = '0;
        pc_next      = 32'h0000_1004;
        set_bubble();
        exp_stall = 1'b0;
        chk_en    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single-cycle ALU ops
        run_op(5'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'h04, 5'd3, AbortNone, -1, 1, 32'd12);
        run_op(5'd7, 32'h8000_0000, 32'h55, 32'd4, 1'b1, 5'h0A, 5'd5, AbortNone, -1, 1,
               32'hF800_0000);
        run_op(5'd4, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'h01, 5'd6, AbortNone, -1, 1, 32'd1);
        run_op(5'd3, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'h01, 5'd7, AbortNone, -1, 1, 32'd0);
        run_op(5'd1, 32'd5, 32'd7, 32'd0, 1'b0, 5'h02, 5'd8, AbortNone, -1, 1, 32'hFFFF_FFFE);
        run_op(5'd2, 32'd1, 32'd9, 32'd33, 1'b1, 5'h03, 5'd9, AbortNone, -1, 1, 32'd2);
        run_op(5'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0, 5'h05, 5'd10, AbortNone, -1,
               1, 32'h0FF0_0FF0);
        run_op(5'd6, 32'h8000_0000, 32'd31, 32'd0, 1'b0, 5'h06, 5'd11, AbortNone, -1, 1, 32'd1);
        run_op(5'd8, 32'h0000_00F0, 32'h0000_000F, 32'd0, 1'b0, 5'h07, 5'd12, AbortNone, -1,
               0, 32'd0);
        run_op(5'd9, 32'hFFFF_0000, 32'h1234_5678, 32'd0, 1'b0, 5'h08, 5'd13, AbortNone, -1,
               0, 32'd0);
        run_op(5'd10, 32'd99, 32'd1, 32'h123, 1'b1, 5'h09, 5'd14, AbortNone, -1, 1, 32'h123);
        run_op(5'd12, 32'd3, 32'd4, 32'd0, 1'b0, 5'h0B, 5'd15, AbortNone, -1, 1, 32'd0);
        run_op(5'd30, 32'd3, 32'd4, 32'd0, 1'b0, 5'h0C, 5'd16, AbortNone, -1, 1, 32'd0);
        idle(2);

        // M-ops, back to back
        run_op(5'd16, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, 5'h11, 5'd1, AbortNone, -1, 1,
               MdEn ? 32'hFFFF_FFEB : 32'd0);
        run_op(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'h11, 5'd2, AbortNone, -1,
               1, MdEn ? 32'hFFFF_FFFE : 32'd0);
        run_op(5'd17, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, 5'h11, 5'd3, AbortNone, -1, 1,
               MdEn ? 32'hFFFF_FFFF : 32'd0);
        run_op(5'd18, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 5'h11, 5'd4, AbortNone, -1, 1,
               MdEn ? 32'hFFFF_FFFF : 32'd0);
        run_op(5'd20, 32'd100, 32'd0, 32'd0, 1'b0, 5'h12, 5'd5, AbortNone, -1, 1,
               MdEn ? 32'hFFFF_FFFF : 32'd0);
        run_op(5'd22, 32'd100, 32'd0, 32'd0, 1'b0, 5'h12, 5'd6, AbortNone, -1, 1,
               MdEn ? 32'd100 : 32'd0);
        run_op(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'h12, 5'd7, AbortNone, -1,
               1, MdEn ? 32'h8000_0000 : 32'd0);
        run_op(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'h12, 5'd8, AbortNone, -1,
               1, 32'd0);
        run_op(5'd22, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 5'h12, 5'd9, AbortNone, -1, 1,
               MdEn ? 32'hFFFF_FFFF : 32'd0);
        run_op(5'd21, 32'd100, 32'd7, 32'd0, 1'b0, 5'h12, 5'd10, AbortNone, -1, 1,
               MdEn ? 32'd14 : 32'd0);
        run_op(5'd23, 32'd100, 32'd7, 32'd0, 1'b0, 5'h12, 5'd11, AbortNone, -1, 1,
               MdEn ? 32'd2 : 32'd0);
        run_op(5'd20, 32'hFFFF_FF9C, 32'd7, 32'd0, 1'b0, 5'h12, 5'd12, AbortNone, -1, 1,
               MdEn ? 32'hFFFF_FFF2 : 32'd0);
        run_op(5'd23, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 5'h12, 5'd13, AbortNone, -1, 1,
               MdEn ? 32'hFFFF_FFFF : 32'd0);
        idle(1);

        // Flush mid-BUSY, then a normal ADD
        run_op(5'd21, 32'd1000, 32'd3, 32'd0, 1'b0, 5'h13, 5'd14, AbortFlush, 10, 0, 32'd0);
        run_op(5'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'h04, 5'd15, AbortNone, -1, 1, 32'd3);
        // Flush of a single-cycle op squashes it
        run_op(5'd0, 32'd8, 32'd8, 32'd0, 1'b0, 5'h04, 5'd16, AbortFlush, 0, 0, 32'd0);
        idle(1);

        // Asynchronous reset mid-BUSY, then a normal ADD
        run_op(5'd16, 32'd6, 32'd7, 32'd0, 1'b0, 5'h11, 5'd17, AbortReset, 5, 0, 32'd0);
        run_op(5'd0, 32'd20, 32'd22, 32'd0, 1'b0, 5'h04, 5'd18, AbortNone, -1, 1, 32'd42);
        idle(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
